// File: rtl/rr_multiplexor_pkg.sv
// Shared definitions for the round-robin multiplexor: mode encoding and
// the wrap-around channel increment used by both the picker and the pointer.
package rr_multiplexor_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

  function automatic int unsigned wrap_inc(input int unsigned k, input int unsigned n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/rr_multiplexor_priority_pick.sv
// Rotating priority encoder: finds the first set request at or after ptr,
// wrapping modulo NUM_CH.
module rr_priority_pick
  import rr_multiplexor_pkg::*;
#(
  parameter int unsigned NUM_CH = 20,
  parameter int unsigned ADDR_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ADDR_W-1:0] ptr,
  output logic              any,
  output logic [ADDR_W-1:0] idx
);

  always_comb begin
    int unsigned k;
    any = 1'b0;
    idx = '0;
    k   = 32'(ptr);
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      if (!any && req[k]) begin
        any = 1'b1;
        idx = ADDR_W'(k);
      end
      k = wrap_inc(k, NUM_CH);
    end
  end

endmodule

// File: rtl/rr_multiplexor.sv
// Registered N-channel multiplexor with valid/ready flow control; selects
// a channel by address (mode 0) or round-robin among requesters (mode 1).
module rr_multiplexor
  import rr_multiplexor_pkg::*;
#(
  parameter int unsigned NUM_CH = 20,
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned ADDR_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [ADDR_W-1:0]       addr,
  output logic [WIDTH-1:0]        out_data,
  output logic [ADDR_W-1:0]       out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    addr_err
);

  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [ADDR_W-1:0] out_ch_q,    out_ch_d;
  logic              addr_err_q,  addr_err_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;

  logic              load_en;
  logic              addr_ok;
  logic              addr_hit;
  logic              pick_any;
  logic [ADDR_W-1:0] pick_idx;
  logic              grant;
  logic [ADDR_W-1:0] gnt_idx;
  logic [WIDTH-1:0]  gnt_data;

  rr_priority_pick #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // No grant while in reset, so no channel sees a transfer that is then dropped.
  always_comb begin
    load_en  = ~out_valid_q | out_ready;
    addr_ok  = {1'b0, addr} < NUM_CH_L;
    addr_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (addr == ADDR_W'(k)) addr_hit = in_valid[k];
    end

    grant   = 1'b0;
    gnt_idx = '0;
    if (load_en && !rst) begin
      if (mode == MODE_RR) begin
        grant   = pick_any;
        gnt_idx = pick_idx;
      end else if (addr_ok && addr_hit) begin
        grant   = 1'b1;
        gnt_idx = addr;
      end
    end

    in_ready = '0;
    gnt_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (gnt_idx == ADDR_W'(k)) begin
        in_ready[k] = grant;
        gnt_data    = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    addr_err_d  = addr_err_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = grant;
      addr_err_d  = (mode == MODE_ADDR) && !addr_ok && (|in_valid);
      if (grant) begin
        out_data_d = gnt_data;
        out_ch_d   = gnt_idx;
        if (mode == MODE_RR) ptr_d = ADDR_W'(wrap_inc(32'(gnt_idx), NUM_CH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      addr_err_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      addr_err_q  <= addr_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign addr_err  = addr_err_q;

endmodule
